adc_scan_ctrl: RTL and testbench

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

---
 rtl/adc_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl
// Periodically scans a set of multiplexed analog channels. Each scan begins
// on a period tick and visits the channels selected in ch_mask in ascending
// index order. For every channel the controller drives the mux select, waits
// for the input to settle, strobes the converter, and offers the result on a
// valid/ready handshake. A tick that arrives while a scan is still running is
// dropped and sets a sticky overrun flag.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                scanning enabled
//   ch_mask[NUM_CH]       channel i is part of the scan when bit i is set
//   period[PER_W]         scan start interval in clk cycles (0 behaves as 1)
//   adc_data[BITS]        converter output for the selected channel
//   mux_sel[CH_W]         registered analog mux select
//   sample                one-cycle convert strobe
//   res_data, res_ch      result value and the channel it came from
//   res_valid, res_ready  result handshake
//   scan_done             one-cycle pulse after the last result of a scan
//   busy                  scan in progress (SETTLE, SAMPLE or PUSH)
//   overrun, overrun_clr  sticky dropped-tick flag and its clear
module adc_scan_ctrl #(
  parameter int BITS       = 12,
  parameter int NUM_CH     = 4,
  parameter int SETTLE_CYC = 8,
  parameter int PER_W      = 16,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [PER_W-1:0]  period,
  input  logic [BITS-1:0]   adc_data,
  output logic [CH_W-1:0]   mux_sel,
  output logic              sample,
  output logic [BITS-1:0]   res_data,
  output logic [CH_W-1:0]   res_ch,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              scan_done,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int SC_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SETTLE,
    SAMPLE,
    PUSH
  } state_t;

  state_t state, state_nx;

  logic [PER_W-1:0]  per_cnt;
  logic [PER_W-1:0]  per_last;
  logic              tick;
  logic [SC_W-1:0]   settle_cnt;
  logic [NUM_CH-1:0] scan_mask;
  logic              abort_q;
  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   next_ch;
  logic              next_ok;
  logic              transfer;

  // ---------------------------------------------------------------------
  // Period counter. A period of 0 is treated as 1, i.e. tick every cycle.
  // The >= compare lets a period shortened mid-count wrap immediately.
  // ---------------------------------------------------------------------
  assign per_last = (period == '0) ? '0 : period - PER_W'(1);
  assign tick     = enable && (per_cnt >= per_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (!enable || tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Channel selection: lowest set bit of the live mask for a scan start,
  // next higher set bit of the latched mask for the following channel.
  // ---------------------------------------------------------------------
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    next_ok  = 1'b0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (ch_mask[i-1]) begin
        first_ch = CH_W'(i - 1);
      end
      if (scan_mask[i-1] && (CH_W'(i - 1) > mux_sel)) begin
        next_ch = CH_W'(i - 1);
        next_ok = 1'b1;
      end
    end
  end

  assign transfer = (state == PUSH) && res_ready;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (enable) state_nx = WAIT;
      end
      WAIT: begin
        if (!enable)                     state_nx = IDLE;
        else if (tick && ch_mask != '0)  state_nx = SETTLE;
      end
      SETTLE: begin
        if (!enable)                                        state_nx = IDLE;
        else if (settle_cnt == SC_W'(SETTLE_CYC - 1))      state_nx = SAMPLE;
      end
      SAMPLE: begin
        state_nx = enable ? PUSH : IDLE;
      end
      PUSH: begin
        // A disable seen at any point while holding a result lets the
        // handshake finish, then abandons the scan without scan_done.
        if (transfer) begin
          if (!enable || abort_q) state_nx = IDLE;
          else if (next_ok)       state_nx = SETTLE;
          else                    state_nx = WAIT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------
  always_comb begin
    sample    = (state == SAMPLE);
    res_valid = (state == PUSH);
    busy      = (state == SETTLE) || (state == SAMPLE) || (state == PUSH);
  end

  // ---------------------------------------------------------------------
  // Datapath and status registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      scan_mask  <= '0;
      mux_sel    <= '0;
      res_data   <= '0;
      res_ch     <= '0;
      scan_done  <= 1'b0;
      abort_q    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      settle_cnt <= (state == SETTLE) ? settle_cnt + SC_W'(1) : '0;

      if (state == WAIT && state_nx == SETTLE) begin
        scan_mask <= ch_mask;
        mux_sel   <= first_ch;
      end else if (state == PUSH && state_nx == SETTLE) begin
        mux_sel <= next_ch;
      end

      if (state == SAMPLE) begin
        res_data <= adc_data;
        res_ch   <= mux_sel;
      end

      scan_done <= (state == PUSH) && (state_nx == WAIT);
      abort_q   <= (state == PUSH) && (abort_q || !enable);

      // A new overrun wins over a clear in the same cycle.
      if (tick && busy) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
module tb_adc_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  ch_mask;
  logic [15:0] period;
  logic [11:0] adc_data;
  logic [1:0]  mux_sel;
  logic        sample;
  logic [11:0] res_data;
  logic [1:0]  res_ch;
  logic        res_valid;
  logic        res_ready;
  logic        scan_done;
  logic        busy;
  logic        overrun;
  logic        overrun_clr;

  logic [11:0] ch_val [4];

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  int first_busy;
  int nres;
  int ndone;
  int odd_sel;
  int rv_t [8];
  int rv_d [8];
  int rv_c [8];
  int unstable;

  adc_scan_ctrl #(
    .BITS       (12),
    .NUM_CH     (4),
    .SETTLE_CYC (8),
    .PER_W      (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .ch_mask     (ch_mask),
    .period      (period),
    .adc_data    (adc_data),
    .mux_sel     (mux_sel),
    .sample      (sample),
    .res_data    (res_data),
    .res_ch      (res_ch),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .scan_done   (scan_done),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  // Converter model: returns the value assigned to the selected channel.
  always_comb adc_data = ch_val[mux_sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_mux_sel"},   32'(mux_sel),   32'd0);
    chk({pfx, "_sample"},    32'(sample),    32'd0);
    chk({pfx, "_res_data"},  32'(res_data),  32'd0);
    chk({pfx, "_res_ch"},    32'(res_ch),    32'd0);
    chk({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({pfx, "_scan_done"}, 32'(scan_done), 32'd0);
    chk({pfx, "_busy"},      32'(busy),      32'd0);
    chk({pfx, "_overrun"},   32'(overrun),   32'd0);
  endtask

  // Leaves the bench at negedge "0" with the DUT idle and enable low.
  task automatic do_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    overrun_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs a fixed number of cycles and records events by negedge index.
  task automatic run_rec(input int cycles);
    first_busy = -1;
    nres       = 0;
    ndone      = 0;
    odd_sel    = 0;
    for (int i = 0; i < 8; i++) begin
      rv_t[i] = 0;
      rv_d[i] = 0;
      rv_c[i] = 0;
    end
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      if (busy && first_busy < 0) first_busy = k;
      if (res_valid && res_ready && nres < 8) begin
        rv_t[nres] = k;
        rv_d[nres] = int'(res_data);
        rv_c[nres] = int'(res_ch);
        nres++;
      end
      if (scan_done) ndone++;
      if (busy && mux_sel[0]) odd_sel++;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    ch_mask     = '0;
    period      = '0;
    res_ready   = 1'b1;
    overrun_clr = 1'b0;
    ch_val[0]   = 12'h111;
    ch_val[1]   = 12'h222;
    ch_val[2]   = 12'h333;
    ch_val[3]   = 12'h444;

    // Reset values
    @(negedge clk);
    chk_reset_vals("rst");

    // Basic scan: period 100, channels 0 and 2
    do_reset();
    period = 16'd100; ch_mask = 4'b0101; res_ready = 1'b1; enable = 1'b1;
    run_rec(130);
    chk("scan_first_busy", 32'(first_busy), 32'd100);
    chk("scan_nres",       32'(nres),       32'd2);
    chk("scan_rv0_time",   32'(rv_t[0]),    32'd109);
    chk("scan_rv0_data",   32'(rv_d[0]),    32'h111);
    chk("scan_rv0_ch",     32'(rv_c[0]),    32'd0);
    chk("scan_rv1_time",   32'(rv_t[1]),    32'd119);
    chk("scan_rv1_data",   32'(rv_d[1]),    32'h333);
    chk("scan_rv1_ch",     32'(rv_c[1]),    32'd2);
    chk("scan_done_cnt",   32'(ndone),      32'd1);
    chk("scan_odd_sel",    32'(odd_sel),    32'd0);
    chk("scan_no_overrun", 32'(overrun),    32'd0);

    // Full-scale and zero values pass through unchanged
    do_reset();
    ch_val[1] = 12'hFFF; ch_val[3] = 12'h000;
    period = 16'd20; ch_mask = 4'b1010; res_ready = 1'b1; enable = 1'b1;
    run_rec(50);
    chk("fs_nres",     32'(nres),    32'd2);
    chk("fs_rv0_data", 32'(rv_d[0]), 32'hFFF);
    chk("fs_rv0_ch",   32'(rv_c[0]), 32'd1);
    chk("fs_rv1_data", 32'(rv_d[1]), 32'h000);
    chk("fs_rv1_ch",   32'(rv_c[1]), 32'd3);
    chk("fs_done_cnt", 32'(ndone),   32'd1);

    // Stalled consumer: result held, ticks dropped, overrun sticky
    do_reset();
    ch_val[0] = 12'h5A5;
    period = 16'd50; ch_mask = 4'b0001; res_ready = 1'b0; enable = 1'b1;
    repeat (59) @(negedge clk);
    chk("stall_valid", 32'(res_valid), 32'd1);
    chk("stall_data",  32'(res_data),  32'h5A5);
    unstable = 0;
    repeat (200) begin
      @(negedge clk);
      if (!res_valid || res_data !== 12'h5A5 || res_ch !== 2'd0 || sample || mux_sel !== 2'd0)
        unstable++;
    end
    chk("stall_stable",  32'(unstable), 32'd0);
    chk("stall_overrun", 32'(overrun),  32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    repeat (39) @(negedge clk);
    overrun_clr = 1'b1;          // coincides with a dropped tick
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr_clr_vs_set", 32'(overrun), 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 32'(res_valid), 32'd0);
    chk("stall_release_done",  32'(scan_done), 32'd1);

    // Empty mask: ticks ignored
    do_reset();
    period = 16'd10; ch_mask = 4'b0000; res_ready = 1'b1; enable = 1'b1;
    unstable = 0;
    repeat (100) begin
      @(negedge clk);
      if (sample || busy || overrun) unstable++;
    end
    chk("empty_mask_quiet", 32'(unstable), 32'd0);

    // Disable during SETTLE
    do_reset();
    period = 16'd10; ch_mask = 4'b0001; res_ready = 1'b1; enable = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_settle_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_settle_idle", 32'(busy), 32'd0);
    unstable = 0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid || sample) unstable++;
    end
    chk("abort_settle_no_res", 32'(unstable), 32'd0);

    // Disable during PUSH: handshake completes, no scan_done
    do_reset();
    period = 16'd10; ch_mask = 4'b0001; res_ready = 1'b0; enable = 1'b1;
    repeat (19) @(negedge clk);
    chk("abort_push_valid", 32'(res_valid), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_push_hold", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("abort_push_released", 32'(res_valid), 32'd0);
    chk("abort_push_no_done",  32'(scan_done), 32'd0);
    chk("abort_push_idle",     32'(busy),      32'd0);

    // Asynchronous reset while holding a result
    do_reset();
    period = 16'd10; ch_mask = 4'b0100; res_ready = 1'b0; enable = 1'b1;
    repeat (25) @(negedge clk);
    chk("prerst_valid",   32'(res_valid), 32'd1);
    chk("prerst_mux",     32'(mux_sel),   32'd2);
    chk("prerst_overrun", 32'(overrun),   32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");

    // Period 0: tick every cycle, one scan every 11 cycles
    do_reset();
    period = 16'd0; ch_mask = 4'b0001; res_ready = 1'b1; enable = 1'b1;
    run_rec(35);
    chk("p0_nres",     32'(nres),              32'd3);
    chk("p0_rv0_time", 32'(rv_t[0]),           32'd11);
    chk("p0_gap1",     32'(rv_t[1] - rv_t[0]), 32'd11);
    chk("p0_gap2",     32'(rv_t[2] - rv_t[1]), 32'd11);
    chk("p0_done_cnt", 32'(ndone),             32'd3);
    chk("p0_overrun",  32'(overrun),           32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
